div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//   Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU ops, in the Execute stage.
//   It is the stall source toward the hazard unit: it drives DivBusy, which the hazard
//   unit ORs into StallF/StallD/StallE. It also obeys the hazard unit's FlushE (kill).
//   One quotient bit per cycle. Result is written back through the E->M pipeline register.
// PARAMETERS
//   XLEN        32   operand/result width
//   CNT_W       5    iteration counter width, $clog2(XLEN)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   DivStartE   in   1      a divide op is in Execute this cycle
//   DivOpE      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   SrcAE       in   XLEN   dividend, already forwarded
//   SrcBE       in   XLEN   divisor, already forwarded
//   RdE         in   5      destination register of the op
//   FlushE      in   1      kill from hazard unit (branch mispredict)
//   DivBusy     out  1      stall request to hazard unit
//   DivDone     out  1      1-cycle pulse: DivResult/DivRd valid
//   DivResult   out  XLEN   quotient or remainder
//   DivRd       out  5      destination register of completed op
// BEHAVIOUR
//   - States: IDLE, CALC, DONE. Reset (async): IDLE. All registers and outputs are 0.
//   - Accept: in IDLE with DivStartE=1 and FlushE=0 (cycle T). Latch |A|, |B|, op, RdE.
//     Latch sign flags. Signed ops take the magnitude of negative operands.
//   - DivBusy = (IDLE & DivStartE & ~FlushE) | CALC. This is combinational, so the
//     stall takes effect in the accept cycle. DivBusy is 0 in DONE, so the pipeline
//     advances while the result is presented.
//   - CALC: restoring step each cycle. rem = {rem[XLEN-2:0], dvd[XLEN-1]}.
//     If rem >= divisor, subtract and set q bit. Counter runs XLEN-1 down to 0.
//     CALC occupies T+1..T+XLEN. DONE is at T+XLEN+1 (latency XLEN+1 = 33).
//   - DONE: DivDone=1 for exactly one cycle. DivResult and DivRd are held registered.
//     Next state is IDLE. A new start is accepted from IDLE at the earliest.
//   - Sign fix-up (signed ops): negate the quotient iff the operand signs differ.
//     The remainder takes the sign of the dividend.
//   - Divide by zero (B==0): fast path. The accept cycle goes straight to DONE at T+1.
//     Quotient = all ones. Remainder = A. This holds for both signed and unsigned.
//   - Signed overflow (A=0x80000000, B=-1, DIV/REM): fast path, DONE at T+1.
//     Quotient = 0x80000000, remainder = 0.
//   - FlushE=1 while in CALC: next state is IDLE and DivBusy drops the next cycle.
//     No DivDone is produced. FlushE in DONE suppresses DivDone in that cycle.
//   - FlushE together with DivStartE in IDLE: the op is not accepted.
//   - DivStartE while in CALC or DONE is ignored (upstream is stalled).
//   - DivResult holds its last value outside DONE. Consumers qualify it with DivDone.
// STRUCTURE
//   - riscv_pkg holds: XLEN, the DIV_OP_* encodings (DIV/DIVU/REM/REMU), and the
//     div_state_t state enum.
//   - Sub-module div_iter_step is purely combinational and computes one restoring step.
//     Inputs: rem, dvd_msb, divisor. Outputs: next_rem, q_bit.
//   - Top level: FSM, counter, operand/sign registers, fix-up and fast-path muxes.
// TESTING
//   - DIVU 100/7 accepted at T: DivBusy is high T..T+32. At T+33, DivDone=1 and
//     DivResult=14. REMU with the same operands gives 2.
//   - DIV -7/2 gives 0xFFFFFFFD (-3). REM -7/2 gives 0xFFFFFFFF (-1).
//     REM 7/-2 gives 1.
//   - DIV 5/0: DivDone at T+1, result 0xFFFFFFFF. REM 5/0 gives 5.
//     DivBusy is high only in cycle T.
//   - DIV 0x80000000/0xFFFFFFFF: result 0x80000000 at T+1. REM gives 0.
//   - Start, then FlushE at T+10: DivBusy=0 at T+11, state IDLE, no DivDone.
//     A new DIVU 9/3 at T+12 returns 3 at T+45.
//   - rst pulsed mid-CALC: outputs go to 0 immediately (async) and state is IDLE.
//     DivStartE+FlushE in the same cycle: no accept and DivBusy stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants, divider op encodings and divider state type
// Contents:
//   XLEN, CNT_W          operand width and iteration counter width
//   DIV_OP_*             DivOpE encodings
//   div_state_t          divider FSM states
//   op_is_signed/op_is_rem  decode helpers for DivOpE
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // The low op bit marks the unsigned variants, the high bit selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - Execute-stage divider request/response bundle
// Signals:
//   DivStartE, DivOpE, SrcAE, SrcBE, RdE, FlushE   pipeline/hazard -> divider
//   DivBusy, DivDone, DivResult, DivRd             divider -> pipeline/hazard
// Modports: master (pipeline side), slave (divider side)
interface div_unit_if;
  import riscv_pkg::*;

  logic            DivStartE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [4:0]      RdE;
  logic            FlushE;
  logic            DivBusy;
  logic            DivDone;
  logic [XLEN-1:0] DivResult;
  logic [4:0]      DivRd;

  modport master (
    output DivStartE, DivOpE, SrcAE, SrcBE, RdE, FlushE,
    input  DivBusy, DivDone, DivResult, DivRd
  );

  modport slave (
    input  DivStartE, DivOpE, SrcAE, SrcBE, RdE, FlushE,
    output DivBusy, DivDone, DivResult, DivRd
  );

endinterface

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational restoring-division step
// Ports:
//   i_rem       in   XLEN  partial remainder (always < i_divisor)
//   i_dvd_msb   in   1     next dividend bit shifted into the remainder
//   i_divisor   in   XLEN  divisor magnitude
//   o_next_rem  out  XLEN  partial remainder after this step
//   o_q_bit     out  1     quotient bit produced by this step
module div_iter_step
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dvd_msb,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_next_rem,
  output logic            o_q_bit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  // One extra bit keeps the shifted remainder exact; since i_rem < divisor the
  // difference's top bit is a clean borrow flag.
  assign w_shift    = {i_rem, i_dvd_msb};
  assign w_diff     = w_shift - {1'b0, i_divisor};
  assign o_q_bit    = ~w_diff[XLEN];
  assign o_next_rem = o_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) in Execute
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous active-high reset
//   bus   slave    div_unit_if: request (DivStartE/DivOpE/SrcAE/SrcBE/RdE/FlushE),
//                  response (DivBusy stall, DivDone pulse, DivResult, DivRd)
module div_unit
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  div_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_dvd;      // dividend magnitude; quotient bits shift in at the LSB
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;
  logic [4:0]      r_rd_lat;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_div_rd;

  logic            w_accept;
  logic            w_signed;
  logic            w_is_rem;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_overflow;
  logic [XLEN-1:0] w_fast_result;
  logic [XLEN-1:0] w_next_rem;
  logic            w_q_bit;
  logic [XLEN-1:0] w_quo_final;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_calc_result;

  assign w_accept = (r_state == ST_IDLE) & bus.DivStartE & ~bus.FlushE;
  assign w_signed = op_is_signed(bus.DivOpE);
  assign w_is_rem = op_is_rem(bus.DivOpE);
  assign w_neg_a  = w_signed & bus.SrcAE[XLEN-1];
  assign w_neg_b  = w_signed & bus.SrcBE[XLEN-1];
  assign w_abs_a  = w_neg_a ? -bus.SrcAE : bus.SrcAE;
  assign w_abs_b  = w_neg_b ? -bus.SrcBE : bus.SrcBE;

  assign w_div_zero = (bus.SrcBE == '0);
  assign w_overflow = w_signed & (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (bus.SrcBE == '1);

  // Divide-by-zero: q = all ones, r = A. Overflow: q = A (0x80000000), r = 0.
  assign w_fast_result = w_div_zero ? (w_is_rem ? bus.SrcAE : '1)
                                    : (w_is_rem ? '0 : bus.SrcAE);

  div_iter_step u_step (
    .i_rem      (r_rem),
    .i_dvd_msb  (r_dvd[XLEN-1]),
    .i_divisor  (r_dvs),
    .o_next_rem (w_next_rem),
    .o_q_bit    (w_q_bit)
  );

  // Final step's outputs feed the sign fix-up directly so DONE follows the last CALC cycle.
  assign w_quo_final   = {r_dvd[XLEN-2:0], w_q_bit};
  assign w_quo_fix     = r_neg_q ? -w_quo_final : w_quo_final;
  assign w_rem_fix     = r_neg_r ? -w_next_rem : w_next_rem;
  assign w_calc_result = r_is_rem ? w_rem_fix : w_quo_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_rd_lat <= '0;
      r_result <= '0;
      r_div_rd <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_div_zero || w_overflow) begin
              r_result <= w_fast_result;
              r_div_rd <= bus.RdE;
              r_state  <= ST_DONE;
            end else begin
              r_dvd    <= w_abs_a;
              r_dvs    <= w_abs_b;
              r_rem    <= '0;
              r_cnt    <= CNT_W'(XLEN - 1);
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_neg_r  <= w_neg_a;
              r_is_rem <= w_is_rem;
              r_rd_lat <= bus.RdE;
              r_state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bus.FlushE) begin
            r_state <= ST_IDLE;
          end else begin
            r_rem <= w_next_rem;
            r_dvd <= w_quo_final;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_calc_result;
              r_div_rd <= r_rd_lat;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Combinational so the stall lands in the accept cycle; released in DONE.
  assign bus.DivBusy   = w_accept | (r_state == ST_CALC);
  assign bus.DivDone   = (r_state == ST_DONE) & ~bus.FlushE;
  assign bus.DivResult = r_result;
  assign bus.DivRd     = r_div_rd;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_unit_if u_if ();

  div_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (u_if.DivDone) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Issues one op, follows it to DivDone and checks stall, latency and result.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    int lat;
    int bad;
    bit fast;
    fast = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    @(posedge clk); #1;
    u_if.DivOpE = op; u_if.SrcAE = a; u_if.SrcBE = b; u_if.RdE = rd;
    u_if.FlushE = 1'b0; u_if.DivStartE = 1'b1;
    @(negedge clk);
    chk("busy_accept", 32'(u_if.DivBusy), 32'd1);
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0;
    u_if.SrcAE = $urandom; u_if.SrcBE = $urandom; u_if.RdE = 5'($urandom); u_if.DivOpE = 2'($urandom);
    lat = 1;
    bad = 0;
    @(negedge clk);
    while (!u_if.DivDone && lat < 40) begin
      if (!u_if.DivBusy) bad++;
      @(posedge clk); #1;
      u_if.DivStartE = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency op%0d a=%h b=%h", op, a, b), 32'(lat), fast ? 32'd1 : 32'd33);
    chk("busy_gaps", 32'(bad), 32'd0);
    chk("busy_in_done", 32'(u_if.DivBusy), 32'd0);
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), u_if.DivResult, exp);
    chk("rd", 32'(u_if.DivRd), 32'(rd));
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(u_if.DivDone), 32'd0);
    chk("result_held", u_if.DivResult, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int sel;

    rst = 1'b1;
    u_if.DivStartE = 1'b0; u_if.DivOpE = 2'b00; u_if.SrcAE = '0;
    u_if.SrcBE = '0; u_if.RdE = '0; u_if.FlushE = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(u_if.DivBusy), 32'd0);
    chk("rst_done", 32'(u_if.DivDone), 32'd0);
    chk("rst_result", u_if.DivResult, 32'd0);
    chk("rst_rd", 32'(u_if.DivRd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14);
    do_op(DIV_OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2);
    do_op(DIV_OP_DIV,  -32'sd7, 32'd2, 5'd3, 32'hFFFF_FFFD);
    do_op(DIV_OP_REM,  -32'sd7, 32'd2, 5'd4, 32'hFFFF_FFFF);
    do_op(DIV_OP_REM,  32'd7, -32'sd2, 5'd5, 32'd1);
    do_op(DIV_OP_DIV,  32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF);
    do_op(DIV_OP_REM,  32'd5, 32'd0, 5'd7, 32'd5);
    do_op(DIV_OP_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    do_op(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
    do_op(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0);
    do_op(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0);

    // Start together with FlushE in IDLE: not accepted, nothing completes.
    @(posedge clk); #1;
    u_if.DivOpE = DIV_OP_DIVU; u_if.SrcAE = 32'd50; u_if.SrcBE = 32'd5;
    u_if.DivStartE = 1'b1; u_if.FlushE = 1'b1;
    @(negedge clk);
    chk("start_flush_busy", 32'(u_if.DivBusy), 32'd0);
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0; u_if.FlushE = 1'b0;
    d0 = done_cnt;
    repeat (36) @(negedge clk);
    #1;
    chk("start_flush_nodone", 32'(done_cnt - d0), 32'd0);
    chk("start_flush_busy_late", 32'(u_if.DivBusy), 32'd0);

    // FlushE at T+10 in CALC.
    @(posedge clk); #1;
    u_if.DivOpE = DIV_OP_DIVU; u_if.SrcAE = 32'd1000; u_if.SrcBE = 32'd3;
    u_if.RdE = 5'd12; u_if.DivStartE = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    u_if.FlushE = 1'b1;
    @(negedge clk);
    chk("flush_calc_busy_t10", 32'(u_if.DivBusy), 32'd1);
    @(posedge clk); #1;
    u_if.FlushE = 1'b0;
    @(negedge clk);
    chk("flush_calc_busy_t11", 32'(u_if.DivBusy), 32'd0);
    chk("flush_calc_done_t11", 32'(u_if.DivDone), 32'd0);
    #1;
    chk("flush_calc_nodone", 32'(done_cnt - d0), 32'd0);
    do_op(DIV_OP_DIVU, 32'd9, 32'd3, 5'd13, 32'd3);

    // FlushE in DONE suppresses the pulse.
    @(posedge clk); #1;
    u_if.DivOpE = DIV_OP_DIV; u_if.SrcAE = 32'd5; u_if.SrcBE = 32'd0;
    u_if.RdE = 5'd14; u_if.DivStartE = 1'b1;
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0; u_if.FlushE = 1'b1;
    @(negedge clk);
    chk("flush_done_nodone", 32'(u_if.DivDone), 32'd0);
    chk("flush_done_busy", 32'(u_if.DivBusy), 32'd0);
    @(posedge clk); #1;
    u_if.FlushE = 1'b0;
    @(negedge clk);
    chk("flush_done_after", 32'(u_if.DivDone), 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    u_if.DivOpE = DIV_OP_DIVU; u_if.SrcAE = 32'd12345; u_if.SrcBE = 32'd7;
    u_if.RdE = 5'd15; u_if.DivStartE = 1'b1;
    @(posedge clk); #1;
    u_if.DivStartE = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(u_if.DivBusy), 32'd0);
    chk("arst_done", 32'(u_if.DivDone), 32'd0);
    chk("arst_result", u_if.DivResult, 32'd0);
    chk("arst_rd", 32'(u_if.DivRd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(DIV_OP_DIVU, 32'd9, 32'd3, 5'd16, 32'd3);

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      do_op(op, a, b, rd, ref_div(op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
